// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer and CLINT machine timer for the RV64 core.
// Takes timer interrupt / ECALL / MRET at commit, stalls and drains the
// pipeline, then writes MEPC, pulses excep_code and finally redirects + flushes.
// MEPC write and excep_code pulse sit in separate cycles because the CSR file
// gives excep_code priority over its write port.
// Optional feature: define TRAP_CTRL_VECTOR_EN to enable vectored mtvec mode
// for the timer interrupt (base + 0x1C when mtvec[1:0] == 2'b01).

`ifndef TRAP_CTRL_DEFS
`define TRAP_CTRL_DEFS
`define REG_ADDR_BUS    11:0
`define MEPC            12'h341
`define EXCEP_CODE_BUS  2:0
`define EXCEP_NONE      3'd0
`define TIME_TRAP_CODE  3'd1
`define ECALL_CODE      3'd2
`define MRET_CODE       3'd3
`endif

module trap_ctrl #(
  parameter int TICK_DIV = 1,
  parameter int XLEN     = 64
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic                   commit_valid,
  input  logic [XLEN-1:0]        commit_pc,
  input  logic                   commit_ecall,
  input  logic                   commit_mret,
  input  logic                   pipe_idle,
  input  logic                   global_trap_ena,
  input  logic                   time_trap_ena,
  input  logic [XLEN-1:0]        excep_mtvec,
  input  logic [XLEN-1:0]        excep_mret_mepc,
  input  logic                   clint_we,
  input  logic                   clint_addr,
  input  logic [XLEN-1:0]        clint_wdata,
  output logic [XLEN-1:0]        clint_rdata,
  output logic                   trap_csr_we,
  output logic [`REG_ADDR_BUS]   trap_csr_waddr,
  output logic [XLEN-1:0]        trap_csr_wdata,
  output logic [`EXCEP_CODE_BUS] excep_code,
  output logic                   stall_req,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_WR_EPC, S_CAUSE, S_REDIRECT
  } state_t;

  state_t                  r_state, w_next;
  logic [XLEN-1:0]         r_mtime, r_mtimecmp;
  logic [TW-1:0]           r_tick;
  logic [XLEN-1:0]         r_pc;
  logic [`EXCEP_CODE_BUS]  r_cause;

  logic                    w_tick_wrap, w_timer_pend, w_irq, w_take;
  logic [XLEN-1:0]         w_base, w_trap_tgt;

  assign w_tick_wrap  = (r_tick == TICK_LAST);
  assign w_timer_pend = (r_mtime >= r_mtimecmp);
  assign w_irq        = w_timer_pend & global_trap_ena & time_trap_ena;
  assign w_take       = (r_state == S_IDLE) & commit_valid &
                        (w_irq | commit_ecall | commit_mret);

  // CLINT timer: prescaled mtime increment, software writes override the tick
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_tick     <= '0;
    end else begin
      if (clint_we && !clint_addr) begin
        r_mtime <= clint_wdata;
        r_tick  <= '0;
      end else if (w_tick_wrap) begin
        r_mtime <= r_mtime + 1'b1;
        r_tick  <= '0;
      end else begin
        r_tick  <= r_tick + 1'b1;
      end
      if (clint_we && clint_addr)
        r_mtimecmp <= clint_wdata;
    end
  end

  assign clint_rdata = cpu_rst ? '0 : (clint_addr ? r_mtimecmp : r_mtime);

  // Capture cause and PC of the event taken in IDLE (timer wins over ECALL/MRET)
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_pc    <= '0;
      r_cause <= `EXCEP_NONE;
    end else if (w_take) begin
      r_pc    <= commit_pc;
      r_cause <= w_irq        ? `TIME_TRAP_CODE :
                 commit_ecall ? `ECALL_CODE     : `MRET_CODE;
    end
  end

  // State register
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; MRET skips the MEPC write
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_take) w_next = S_DRAIN;
      S_DRAIN:    if (pipe_idle)
                    w_next = (r_cause == `MRET_CODE) ? S_CAUSE : S_WR_EPC;
      S_WR_EPC:   w_next = S_CAUSE;
      S_CAUSE:    w_next = S_REDIRECT;
      S_REDIRECT: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_base = {excep_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTOR_EN
  assign w_trap_tgt = ((excep_mtvec[1:0] == 2'b01) && (r_cause == `TIME_TRAP_CODE))
                      ? w_base + XLEN'(28) : w_base;
`else
  logic w_unused_mode;
  assign w_unused_mode = ^excep_mtvec[1:0];
  assign w_trap_tgt    = w_base;
`endif

  // Moore outputs; forced quiet while reset is asserted so no partial write escapes
  always_comb begin
    trap_csr_we    = 1'b0;
    trap_csr_waddr = '0;
    trap_csr_wdata = '0;
    excep_code     = `EXCEP_NONE;
    stall_req      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!cpu_rst) begin
      case (r_state)
        S_DRAIN:  stall_req = 1'b1;
        S_WR_EPC: begin
          stall_req      = 1'b1;
          trap_csr_we    = 1'b1;
          trap_csr_waddr = `MEPC;
          trap_csr_wdata = {r_pc[XLEN-1:2], 2'b00};
        end
        S_CAUSE: begin
          stall_req  = 1'b1;
          excep_code = r_cause;
        end
        S_REDIRECT: begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
          redirect_pc    = (r_cause == `MRET_CODE) ? excep_mret_mepc : w_trap_tgt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl (TICK_DIV = 4).
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_ecall, commit_mret, pipe_idle;
  logic [63:0] commit_pc;
  logic        global_trap_ena, time_trap_ena;
  logic [63:0] excep_mtvec, excep_mret_mepc;
  logic        clint_we, clint_addr;
  logic [63:0] clint_wdata, clint_rdata;
  logic        trap_csr_we;
  logic [11:0] trap_csr_waddr;
  logic [63:0] trap_csr_wdata;
  logic [2:0]  excep_code;
  logic        stall_req, flush, redirect_valid;
  logic [63:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_tvec;

  always #5 clk = ~clk;

  trap_ctrl #(.TICK_DIV(4), .XLEN(64)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_ecall(commit_ecall), .commit_mret(commit_mret),
    .pipe_idle(pipe_idle), .global_trap_ena(global_trap_ena),
    .time_trap_ena(time_trap_ena), .excep_mtvec(excep_mtvec),
    .excep_mret_mepc(excep_mret_mepc), .clint_we(clint_we),
    .clint_addr(clint_addr), .clint_wdata(clint_wdata),
    .clint_rdata(clint_rdata), .trap_csr_we(trap_csr_we),
    .trap_csr_waddr(trap_csr_waddr), .trap_csr_wdata(trap_csr_wdata),
    .excep_code(excep_code), .stall_req(stall_req), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clint_wr(input logic a, input logic [63:0] d);
    clint_we = 1'b1; clint_addr = a; clint_wdata = d;
    tick();
    clint_we = 1'b0;
  endtask

  task automatic rd_time(input logic a);
    clint_addr = a; #1;
  endtask

  initial begin
`ifdef TRAP_CTRL_VECTOR_EN
    exp_tvec = 64'h8000_011C;
`else
    exp_tvec = 64'h8000_0100;
`endif
    rst = 1'b1; commit_valid = 0; commit_ecall = 0; commit_mret = 0;
    commit_pc = '0; pipe_idle = 1; global_trap_ena = 0; time_trap_ena = 0;
    excep_mtvec = 64'h8000_0101; excep_mret_mepc = '0;
    clint_we = 0; clint_addr = 0; clint_wdata = '0;

    // reset state
    tick(); tick();
    chk("rst_stall", stall_req, 0);
    chk("rst_we", trap_csr_we, 0);
    chk("rst_code", excep_code, 0);
    chk("rst_redir", redirect_valid, 0);
    rst = 1'b0;
    rd_time(1);
    chk("rst_mtimecmp", clint_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

    // timer interrupt
    clint_wr(1, 64'd5);
    clint_wr(0, 64'd3);
    global_trap_ena = 1; time_trap_ena = 1;
    commit_valid = 1; commit_pc = 64'h8000_0010;
    repeat (7) tick();
    chk("tmr_wait_stall", stall_req, 0);
    tick();
    rd_time(0);
    chk("tmr_mtime5", clint_rdata, 64'd5);
    chk("tmr_pre_stall", stall_req, 0);
    tick();
    chk("tmr_drain_stall", stall_req, 1);
    chk("tmr_drain_we", trap_csr_we, 0);
    tick();
    chk("tmr_epc_we", trap_csr_we, 1);
    chk("tmr_epc_addr", trap_csr_waddr, 12'h341);
    chk("tmr_epc_data", trap_csr_wdata, 64'h8000_0010);
    chk("tmr_epc_code", excep_code, 0);
    tick();
    chk("tmr_cause_code", excep_code, 3'd1);
    chk("tmr_cause_we", trap_csr_we, 0);
    chk("tmr_cause_redir", redirect_valid, 0);
    global_trap_ena = 0;
    tick();
    chk("tmr_redir_v", redirect_valid, 1);
    chk("tmr_redir_flush", flush, 1);
    chk("tmr_redir_stall", stall_req, 0);
    chk("tmr_redir_pc", redirect_pc, exp_tvec);
    chk("tmr_redir_code", excep_code, 0);
    commit_valid = 0;
    tick();
    chk("tmr_idle_redir", redirect_valid, 0);

    // ECALL with slow drain
    commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0040; pipe_idle = 0;
    tick();
    commit_valid = 0; commit_ecall = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ec_drain_stall", stall_req, 1);
      chk("ec_drain_we", trap_csr_we, 0);
      if (i < 2) tick();
    end
    pipe_idle = 1;
    tick();
    chk("ec_epc_we", trap_csr_we, 1);
    chk("ec_epc_data", trap_csr_wdata, 64'h8000_0040);
    tick();
    chk("ec_cause_code", excep_code, 3'd2);
    tick();
    chk("ec_redir_v", redirect_valid, 1);
    chk("ec_redir_pc", redirect_pc, 64'h8000_0100);
    tick();

    // MRET
    excep_mret_mepc = 64'h8000_0044;
    commit_valid = 1; commit_mret = 1; commit_pc = 64'h8000_0050;
    tick();
    commit_valid = 0; commit_mret = 0;
    chk("mr_drain_stall", stall_req, 1);
    tick();
    chk("mr_cause_code", excep_code, 3'd3);
    chk("mr_cause_we", trap_csr_we, 0);
    tick();
    chk("mr_redir_v", redirect_valid, 1);
    chk("mr_redir_pc", redirect_pc, 64'h8000_0044);
    tick();

    // irq and ECALL together: timer wins (mtime is past mtimecmp)
    global_trap_ena = 1;
    commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_0080;
    tick();
    commit_valid = 0; commit_ecall = 0;
    tick();
    chk("both_epc_data", trap_csr_wdata, 64'h8000_0080);
    tick();
    chk("both_cause_code", excep_code, 3'd1);
    global_trap_ena = 0;
    tick();
    chk("both_redir_pc", redirect_pc, exp_tvec);
    tick();

    // mtime wrap with TICK_DIV = 4, write overriding the tick
    clint_wr(0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) tick();
    rd_time(0);
    chk("wrap_hold", clint_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap_zero", clint_rdata, 64'd0);
    clint_wr(0, 64'h100);
    repeat (3) tick();
    clint_wr(0, 64'h200);
    rd_time(0);
    chk("wr_wins", clint_rdata, 64'h200);
    repeat (3) tick();
    chk("wr_clr_hold", clint_rdata, 64'h200);
    tick();
    chk("wr_clr_inc", clint_rdata, 64'h201);

    // reset in the WR_EPC cycle
    commit_valid = 1; commit_ecall = 1; commit_pc = 64'h8000_00C0;
    tick();
    commit_valid = 0; commit_ecall = 0;
    tick();
    rst = 1'b1; #1;
    chk("rst_mid_we", trap_csr_we, 0);
    tick();
    rst = 1'b0;
    rd_time(1);
    chk("rst_mid_cmp", clint_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_time(0);
    chk("rst_mid_mtime", clint_rdata, 64'd0);
    chk("rst_mid_stall", stall_req, 0);
    tick();
    chk("rst_idle_code", excep_code, 0);
    chk("rst_idle_we", trap_csr_we, 0);
    tick();
    chk("rst_idle_redir", redirect_valid, 0);
    chk("rst_idle_stall", stall_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
